// File: rtl/proc_scheduler.sv
// rtl/proc_scheduler.sv - round-robin process scheduler for the multi-process MIPS core
//
// Holds a resume-PC table and a valid bit per process slot. It switches the running
// process on a voluntary yield (op_procmgr), on process end (op_endproc) or, with
// PROC_PREEMPT_EN defined, when the time-slice quantum expires. While a switch is in
// flight it holds the core PC, then pulses pc_load with the PC of the chosen slot.
//
// Optional feature macro: PROC_PREEMPT_EN (quantum counter and preemptive switching).
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   instr_ret        instruction retired this cycle
//   op_procmgr       yield opcode retired
//   op_endproc       end-of-process opcode retired
//   op_endmain       stop-scheduler opcode retired
//   resume_pc        PC at which the current process resumes
//   launch           create process launch_pid starting at launch_pc
//   pc_load          one-cycle pulse: core PC <= sched_pc
//   sched_pc         PC to load, valid with pc_load
//   cur_pid          currently running slot
//   hold_pc          core must suppress PC writes
//   active_mask      valid bits of all slots
//   idle             no valid process, waiting for launch
//   halted           sticky after op_endmain
`timescale 1ns/1ps

module proc_scheduler #(
    parameter int NPROC   = 4,
    parameter int PID_W   = 2,
    parameter int PC_W    = 10,
    parameter int QUANTUM = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_ret,
    input  logic             op_procmgr,
    input  logic             op_endproc,
    input  logic             op_endmain,
    input  logic [PC_W-1:0]  resume_pc,
    input  logic             launch,
    input  logic [PID_W-1:0] launch_pid,
    input  logic [PC_W-1:0]  launch_pc,
    output logic             pc_load,
    output logic [PC_W-1:0]  sched_pc,
    output logic [PID_W-1:0] cur_pid,
    output logic             hold_pc,
    output logic [NPROC-1:0] active_mask,
    output logic             idle,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_LOAD,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  table_q [NPROC];
    logic [PC_W-1:0]  table_d [NPROC];
    logic [NPROC-1:0] active_q, active_d;
    logic [PID_W-1:0] cur_pid_q, cur_pid_d;
    logic [PC_W-1:0]  sched_pc_q, sched_pc_d;
    logic [PC_W-1:0]  save_pc_q, save_pc_d;

    logic             expire;
    logic             clr_cur;
    logic             wr_save;
    logic             sel_found;
    logic [PID_W-1:0] sel_pid;
    logic [PID_W-1:0] cand;

`ifdef PROC_PREEMPT_EN
    localparam int CNT_W = $clog2(QUANTUM + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at 1 so an expiry that loses priority to an opcode cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_LOAD) begin
            cnt_d = CNT_W'(QUANTUM);
        end else if (state_q == S_RUN && instr_ret && cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expire = instr_ret && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(QUANTUM);
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_quantum = QUANTUM;
    logic unused_instr_ret;
    assign unused_instr_ret = instr_ret;
    assign expire           = 1'b0;
`endif

    // Round-robin search starting after the current slot; the current slot is
    // visited last so a lone process that yields is reselected.
    always_comb begin
        sel_found = 1'b0;
        sel_pid   = cur_pid_q;
        cand      = '0;
        for (int i = 1; i <= NPROC; i++) begin
            cand = cur_pid_q + PID_W'(i);
            if (!sel_found && active_q[cand]) begin
                sel_found = 1'b1;
                sel_pid   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        clr_cur = 1'b0;
        wr_save = 1'b0;
        case (state_q)
            S_IDLE:   if (|active_q) state_d = S_SELECT;
            S_RUN: begin
                if (op_endmain) begin
                    state_d = S_HALT;
                end else if (op_endproc) begin
                    clr_cur = 1'b1;
                    state_d = S_SELECT;
                end else if (op_procmgr || expire) begin
                    state_d = S_SAVE;
                end
            end
            S_SAVE: begin
                wr_save = 1'b1;
                state_d = S_SELECT;
            end
            S_SELECT: state_d = sel_found ? S_LOAD : S_IDLE;
            S_LOAD:   state_d = S_RUN;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active_d   = active_q;
        table_d    = table_q;
        cur_pid_d  = cur_pid_q;
        sched_pc_d = sched_pc_q;
        // Captured every RUN cycle so SAVE sees the value from the triggering cycle.
        save_pc_d  = (state_q == S_RUN) ? resume_pc : save_pc_q;

        if (clr_cur) active_d[cur_pid_q] = 1'b0;
        if (wr_save) table_d[cur_pid_q]  = save_pc_q;

        // cur_pid and sched_pc are registered on entry to LOAD so they are
        // already valid during the pc_load cycle.
        if (state_q == S_SELECT && sel_found) begin
            cur_pid_d  = sel_pid;
            sched_pc_d = table_q[sel_pid];
        end

        // Applied last: a launch overrides an endproc clear of the same slot.
        if (launch && state_q != S_HALT) begin
            active_d[launch_pid] = 1'b1;
            table_d[launch_pid]  = launch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            active_q   <= '0;
            cur_pid_q  <= '0;
            sched_pc_q <= '0;
            save_pc_q  <= '0;
            for (int i = 0; i < NPROC; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            cur_pid_q  <= cur_pid_d;
            sched_pc_q <= sched_pc_d;
            save_pc_q  <= save_pc_d;
            table_q    <= table_d;
        end
    end

    assign pc_load     = (state_q == S_LOAD);
    assign sched_pc    = sched_pc_q;
    assign cur_pid     = cur_pid_q;
    assign hold_pc     = (state_q != S_RUN);
    assign active_mask = active_q;
    assign idle        = (state_q == S_IDLE);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_proc_scheduler.sv
// tb/tb_proc_scheduler.sv - scoreboard testbench for proc_scheduler
`timescale 1ns/1ps

module tb_proc_scheduler;

    localparam int NPROC   = 4;
    localparam int PID_W   = 2;
    localparam int PC_W    = 10;
    localparam int QUANTUM = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             instr_ret = 1'b0;
    logic             op_procmgr = 1'b0;
    logic             op_endproc = 1'b0;
    logic             op_endmain = 1'b0;
    logic [PC_W-1:0]  resume_pc = '0;
    logic             launch = 1'b0;
    logic [PID_W-1:0] launch_pid = '0;
    logic [PC_W-1:0]  launch_pc = '0;
    logic             pc_load;
    logic [PC_W-1:0]  sched_pc;
    logic [PID_W-1:0] cur_pid;
    logic             hold_pc;
    logic [NPROC-1:0] active_mask;
    logic             idle;
    logic             halted;

    proc_scheduler #(
        .NPROC(NPROC), .PID_W(PID_W), .PC_W(PC_W), .QUANTUM(QUANTUM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_ret(instr_ret),
        .op_procmgr(op_procmgr), .op_endproc(op_endproc), .op_endmain(op_endmain),
        .resume_pc(resume_pc), .launch(launch), .launch_pid(launch_pid),
        .launch_pc(launch_pc), .pc_load(pc_load), .sched_pc(sched_pc),
        .cur_pid(cur_pid), .hold_pc(hold_pc), .active_mask(active_mask),
        .idle(idle), .halted(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int pc;
        int pid;
        int at;
        int mask;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every pc_load must match the oldest expected switch.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pc_load) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pc_load at cycle %0d: got pc_load=1 sched_pc=0x%0h, expected no load", cyc, sched_pc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("load_cycle", cyc, mon_e.at);
                    check("sched_pc", int'(sched_pc), mon_e.pc);
                    check("cur_pid", int'(cur_pid), mon_e.pid);
                    check("active_mask_at_load", int'(active_mask), mon_e.mask);
                end
            end else if (sbq.size() > 0 && sbq[0].at < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missed_pc_load at cycle %0d: got no load, expected load at cycle %0d", cyc, sbq[0].at);
                void'(sbq.pop_front());
            end
        end
    end

    // Reference model: slot table, valid bits, running slot, quantum left.
    int m_tbl[NPROC];
    bit m_act[NPROC];
    int m_cur;
    int m_cnt;
    int run_from;
    int idle_from;

    function automatic int pick_next();
        for (int i = 1; i <= NPROC; i++) begin
            int p = (m_cur + i) % NPROC;
            if (m_act[p]) return p;
        end
        return -1;
    endfunction

    function automatic int mask_of();
        int m = 0;
        for (int i = 0; i < NPROC; i++) if (m_act[i]) m += (1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NPROC; i++) begin
            m_tbl[i] = 0;
            m_act[i] = 1'b0;
        end
        m_cur    = 0;
        m_cnt    = QUANTUM;
        run_from = -1;
        idle_from = 0;
        sbq.delete();
    endtask

    task automatic schedule(int trig, int lat);
        int n;
        exp_t e;
        n = pick_next();
        if (n >= 0) begin
            e.pc = m_tbl[n]; e.pid = n; e.at = trig + lat; e.mask = mask_of();
            sbq.push_back(e);
            m_cur    = n;
            m_cnt    = QUANTUM;
            run_from = trig + lat + 1;
        end else begin
            run_from  = -1;
            idle_from = trig + lat;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        instr_ret  = 1'b0;
        op_procmgr = 1'b0;
        op_endproc = 1'b0;
        op_endmain = 1'b0;
        launch     = 1'b0;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic launch_now(int pid, int pc);
        launch     = 1'b1;
        launch_pid = PID_W'(pid);
        launch_pc  = PC_W'(pc);
        m_tbl[pid] = pc;
        m_act[pid] = 1'b1;
    endtask

    task automatic start_from_idle(int pid, int pc);
        launch_now(pid, pc);
        schedule(cyc, 3);
    endtask

    task automatic act_retire(int rpc);
        instr_ret = 1'b1;
        resume_pc = PC_W'(rpc);
`ifdef PROC_PREEMPT_EN
        if (m_cnt == 1) begin
            m_tbl[m_cur] = rpc;
            schedule(cyc, 3);
        end else begin
            m_cnt--;
        end
`endif
    endtask

    task automatic act_yield(int rpc);
        instr_ret    = 1'b1;
        op_procmgr   = 1'b1;
        resume_pc    = PC_W'(rpc);
        m_tbl[m_cur] = rpc;
        schedule(cyc, 3);
    endtask

    task automatic act_endproc(bit with_l, int lp, int lpc);
        instr_ret  = 1'b1;
        op_endproc = 1'b1;
        if (with_l) launch_now(lp, lpc);
        if (!(with_l && lp == m_cur)) m_act[m_cur] = 1'b0;
        schedule(cyc, 2);
    endtask

    // Advance through a pending switch; if nothing is left to run, launch lp.
    task automatic settle(int lp, int lpc);
        tick();
        if (run_from < 0) begin
            wait_until(idle_from);
            check("idle_when_empty", int'(idle), 1);
            check("hold_when_empty", int'(hold_pc), 1);
            check("mask_when_empty", int'(active_mask), 0);
            start_from_idle(lp, lpc);
            tick();
        end
        wait_until(run_from);
        check("hold_pc_in_run", int'(hold_pc), 0);
    endtask

    function automatic bit switching();
        return (run_from < 0) || (run_from > cyc);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion, expected finish within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        model_reset();

        #3;
        check("rst_pc_load", int'(pc_load), 0);
        check("rst_sched_pc", int'(sched_pc), 0);
        check("rst_cur_pid", int'(cur_pid), 0);
        check("rst_hold_pc", int'(hold_pc), 1);
        check("rst_active_mask", int'(active_mask), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_halted", int'(halted), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // First launch out of IDLE.
        start_from_idle(0, 'h040);
        tick();
        wait_until(run_from);
        check("first_run_hold", int'(hold_pc), 0);

        // Yield from pid0 to pid2.
        launch_now(2, 'h080);
        tick();
        act_yield('h045);
        settle(0, 0);

        // Long retire run: preemption only when the quantum feature is built in.
        for (int i = 0; i < 100; i++) begin
            act_retire($urandom_range(0, 1023));
            if (switching()) settle(0, 'h040);
            else tick();
        end
`ifndef PROC_PREEMPT_EN
        check("coop_no_switch_pid", int'(cur_pid), m_cur);
`endif
        act_yield('h0A5);
        settle(0, 0);

        // Reset in the middle of a switch: no load may follow.
        act_yield('h3AA);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_pc_load", int'(pc_load), 0);
        check("midrst_hold", int'(hold_pc), 1);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("midrst_idle", int'(idle), 1);
        check("midrst_mask", int'(active_mask), 0);

        // Ending the only process goes idle, then a new launch runs.
        start_from_idle(1, 'h100);
        tick();
        wait_until(run_from);
        act_endproc(1'b0, 0, 0);
        settle(3, 'h1F0);

        // Lone process yields and is reselected with its saved PC.
        act_yield('h1F5);
        settle(0, 0);

        // Same-cycle endproc and launch on the running slot.
        launch_now(1, 'h111);
        tick();
        act_yield('h1F6);
        settle(0, 0);
        act_endproc(1'b1, 1, 'h200);
        settle(0, 0);
        act_yield('h1F7);
        settle(0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                act_retire($urandom_range(0, 1023));
            end else if (r < 62) begin
                resume_pc = PC_W'($urandom_range(0, 1023));
            end else if (r < 77) begin
                act_yield($urandom_range(0, 1023));
            end else if (r < 88) begin
                act_endproc(1'($urandom_range(0, 1)), $urandom_range(0, NPROC - 1),
                            $urandom_range(0, 1023));
            end else begin
                launch_now($urandom_range(0, NPROC - 1), $urandom_range(0, 1023));
            end
            if (switching()) settle($urandom_range(0, NPROC - 1), $urandom_range(0, 1023));
            else tick();
        end

        // Halt: terminal, launches ignored, left only by reset.
        instr_ret  = 1'b1;
        op_endmain = 1'b1;
        tick();
        tick();
        check("halt_halted", int'(halted), 1);
        check("halt_hold", int'(hold_pc), 1);
        check("halt_not_idle", int'(idle), 0);
        launch_pc  = PC_W'('h2AA);
        launch_pid = PID_W'(m_cur + 1);
        launch     = 1'b1;
        tick();
        tick();
        check("halt_launch_ignored", int'(active_mask), mask_of());
        check("halt_sticky", int'(halted), 1);
        rst_n = 1'b0;
        #1;
        check("final_rst_pc_load", int'(pc_load), 0);
        check("final_rst_sched_pc", int'(sched_pc), 0);
        check("final_rst_cur_pid", int'(cur_pid), 0);
        check("final_rst_hold", int'(hold_pc), 1);
        check("final_rst_mask", int'(active_mask), 0);
        check("final_rst_idle", int'(idle), 1);
        check("final_rst_halted", int'(halted), 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        check("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
